// File: rtl/fft_stage_sequencer.sv
// Control FSM for the mixed-radix (5,3,2) in-place FFT: validates N, issues butterflies stage by stage, then output reads.
// Latency: start at t -> size check t+1, stage setup t+2, first butterfly command valid at t+3.
// Backpressure: command and address fields hold stable while valid && !ready; each stage waits for eng_busy low.
module fft_stage_sequencer #(
    parameter int AW    = 11,
    parameter int MAX_N = 1200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    cfg_a,
    input  logic [1:0]    cfg_b,
    input  logic [1:0]    cfg_c,
    output logic          bfly_valid,
    input  logic          bfly_ready,
    output logic [2:0]    bfly_radix,
    output logic [AW-1:0] bfly_base,
    output logic [AW-1:0] bfly_stride,
    output logic [AW-1:0] bfly_tw,
    input  logic          eng_busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          finish,
    output logic          err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [2:0]    state;
    logic [3:0]    cfg_a_q;
    logic [1:0]    cfg_b_q;
    logic [1:0]    cfg_c_q;
    logic [1:0]    rem5;
    logic [1:0]    rem3;
    logic [3:0]    rem2;
    logic [AW-1:0] n_q;
    logic [AW-1:0] m_q;      // N / P: span of one group in the current stage
    logic [AW-1:0] p_q;      // product of completed radices = group count
    logic [AW-1:0] j_q;
    logic [AW-1:0] g_q;
    logic [AW-1:0] gbase_q;  // g * S * r

    logic [4:0]    pow3;
    logic [6:0]    pow5;
    logic [11:0]   p35;
    logic [31:0]   n_full;
    logic          n_ok;
    logic [2:0]    r_sel;
    logic [AW-1:0] s_next;
    logic [AW-1:0] p_next;

    always_comb begin
        case (cfg_b_q)
            2'd0:    pow3 = 5'd1;
            2'd1:    pow3 = 5'd3;
            2'd2:    pow3 = 5'd9;
            default: pow3 = 5'd27;
        endcase
        case (cfg_c_q)
            2'd0:    pow5 = 7'd1;
            2'd1:    pow5 = 7'd5;
            2'd2:    pow5 = 7'd25;
            default: pow5 = 7'd125;
        endcase
        p35    = 12'(pow3) * 12'(pow5);
        n_full = 32'(p35) << cfg_a_q;
        n_ok   = (n_full <= 32'(MAX_N)) && (n_full != 32'd1);
    end

    // Radix order is 5, then 3, then 2; the stride divide is the only divider.
    always_comb begin
        if (rem5 != 2'd0) begin
            r_sel  = 3'd5;
            s_next = m_q / AW'(5);
        end else if (rem3 != 2'd0) begin
            r_sel  = 3'd3;
            s_next = m_q / AW'(3);
        end else begin
            r_sel  = 3'd2;
            s_next = m_q >> 1;
        end
    end

    always_comb begin
        case (bfly_radix)
            3'd5:    p_next = p_q + (p_q << 2);
            3'd3:    p_next = p_q + (p_q << 1);
            default: p_next = p_q << 1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cfg_a_q     <= '0;
            cfg_b_q     <= '0;
            cfg_c_q     <= '0;
            rem5        <= '0;
            rem3        <= '0;
            rem2        <= '0;
            n_q         <= '0;
            m_q         <= '0;
            p_q         <= '0;
            j_q         <= '0;
            g_q         <= '0;
            gbase_q     <= '0;
            bfly_valid  <= 1'b0;
            bfly_radix  <= '0;
            bfly_base   <= '0;
            bfly_stride <= '0;
            bfly_tw     <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            err         <= 1'b0;
        end else begin
            err    <= 1'b0;
            finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_a_q <= cfg_a;
                        cfg_b_q <= cfg_b;
                        cfg_c_q <= cfg_c;
                        busy    <= 1'b1;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (n_ok) begin
                        n_q   <= n_full[AW-1:0];
                        m_q   <= n_full[AW-1:0];
                        p_q   <= ONE;
                        rem5  <= cfg_c_q;
                        rem3  <= cfg_b_q;
                        rem2  <= cfg_a_q;
                        state <= S_SETUP;
                    end else begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    case (r_sel)
                        3'd5:    rem5 <= rem5 - 2'd1;
                        3'd3:    rem3 <= rem3 - 2'd1;
                        default: rem2 <= rem2 - 4'd1;
                    endcase
                    bfly_radix  <= r_sel;
                    bfly_stride <= s_next;
                    bfly_base   <= '0;
                    bfly_tw     <= '0;
                    bfly_valid  <= 1'b1;
                    j_q         <= '0;
                    g_q         <= '0;
                    gbase_q     <= '0;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bfly_ready) begin
                        if (j_q == bfly_stride - ONE) begin
                            j_q       <= '0;
                            bfly_tw   <= '0;
                            gbase_q   <= gbase_q + m_q;
                            bfly_base <= gbase_q + m_q;
                            g_q       <= g_q + ONE;
                            if (g_q == p_q - ONE) begin
                                // Stage complete: next stage sees P*r groups of span S.
                                bfly_valid <= 1'b0;
                                p_q        <= p_next;
                                m_q        <= bfly_stride;
                                state      <= S_DRAIN;
                            end
                        end else begin
                            j_q       <= j_q + ONE;
                            bfly_tw   <= bfly_tw + p_q;
                            bfly_base <= bfly_base + ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!eng_busy) begin
                        if ((rem5 != 2'd0) || (rem3 != 2'd0) || (rem2 != 4'd0)) begin
                            state <= S_SETUP;
                        end else begin
                            out_valid <= 1'b1;
                            out_addr  <= '0;
                            state     <= S_OUTPUT;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (out_addr == n_q - ONE) begin
                            out_valid <= 1'b0;
                            finish    <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            out_addr <= out_addr + ONE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: reference stage model fills command/address queues, monitor pops on handshakes.
module tb_fft_stage_sequencer;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    cfg_a = '0;
    logic [1:0]    cfg_b = '0;
    logic [1:0]    cfg_c = '0;
    logic          bfly_valid;
    logic          bfly_ready = 1'b0;
    logic [2:0]    bfly_radix;
    logic [AW-1:0] bfly_base;
    logic [AW-1:0] bfly_stride;
    logic [AW-1:0] bfly_tw;
    logic          eng_busy = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          finish;
    logic          err;

    fft_stage_sequencer #(.AW(AW), .MAX_N(1200)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
        .bfly_valid(bfly_valid), .bfly_ready(bfly_ready), .bfly_radix(bfly_radix),
        .bfly_base(bfly_base), .bfly_stride(bfly_stride), .bfly_tw(bfly_tw),
        .eng_busy(eng_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .busy(busy), .finish(finish), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    radix;
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [AW-1:0] tw;
    } cmd_t;

    cmd_t exp_cmd[$];
    int   exp_out[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   hs_cnt = 0;
    int   fin_cnt = 0;
    int   err_cnt = 0;
    bit   rnd_mode = 1'b0;
    bit   rdy_fixed = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [51:0] all_outs();
        return {bfly_valid, bfly_radix, bfly_base, bfly_stride, bfly_tw,
                out_valid, out_addr, busy, finish, err};
    endfunction

    // Reference: stage k has radix r, stride S = N/(P*r), commands g-major then j.
    task automatic push_model(input int a, input int b, input int c);
        int n, p, s, r;
        cmd_t cm;
        n = 1 << a;
        for (int i = 0; i < b; i++) n = n * 3;
        for (int i = 0; i < c; i++) n = n * 5;
        p = 1;
        for (int k = 0; k < a + b + c; k++) begin
            r = (k < c) ? 5 : ((k < c + b) ? 3 : 2);
            s = n / (p * r);
            for (int g = 0; g < p; g++) begin
                for (int j = 0; j < s; j++) begin
                    cm.radix  = 3'(r);
                    cm.base   = AW'(g * s * r + j);
                    cm.stride = AW'(s);
                    cm.tw     = AW'(j * p);
                    exp_cmd.push_back(cm);
                end
            end
            p = p * r;
        end
        for (int i = 0; i < n; i++) exp_out.push_back(i);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_mode) begin
                bfly_ready = 1'($urandom_range(0, 1));
                out_ready  = 1'($urandom_range(0, 1));
            end else begin
                bfly_ready = rdy_fixed;
                out_ready  = rdy_fixed;
            end
        end
    end

    cmd_t          cur;
    cmd_t          held;
    bit            stall_q = 1'b0;
    bit            ostall_q = 1'b0;
    logic [AW-1:0] held_addr;

    always @(negedge clk) begin
        cur = {bfly_radix, bfly_base, bfly_stride, bfly_tw};
        if (reset) begin
            stall_q  = 1'b0;
            ostall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("bfly_stall_valid", 64'(bfly_valid), 64'd1);
                chk("bfly_stall_fields", 64'(cur), 64'(held));
            end
            if (ostall_q) begin
                chk("out_stall_valid", 64'(out_valid), 64'd1);
                chk("out_stall_addr", 64'(out_addr), 64'(held_addr));
            end
            if (bfly_valid && bfly_ready) begin
                hs_cnt++;
                chk("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
                if (exp_cmd.size() != 0) chk("cmd", 64'(cur), 64'(exp_cmd.pop_front()));
            end
            if (out_valid && out_ready) begin
                chk("addr_expected", 64'(exp_out.size() != 0), 64'd1);
                if (exp_out.size() != 0) chk("out_addr", 64'(out_addr), 64'(exp_out.pop_front()));
            end
            if (finish) begin
                fin_cnt++;
                chk("finish_drained", 64'(exp_cmd.size() + exp_out.size()), 64'd0);
            end
            if (err) err_cnt++;
            stall_q   = bfly_valid && !bfly_ready;
            ostall_q  = out_valid && !out_ready;
            held      = cur;
            held_addr = out_addr;
        end
    end

    task automatic do_start(input int a, input int b, input int c);
        cfg_a = 4'(a);
        cfg_b = 2'(b);
        cfg_c = 2'(c);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget, input string tag);
        int f0;
        int k;
        f0 = fin_cnt;
        k  = 0;
        while (fin_cnt == f0 && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 64'(fin_cnt - f0), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        repeat (3) cyc();
        chk({tag, "_single_finish"}, 64'(fin_cnt - f0), 64'd1);
        chk({tag, "_cmds_left"}, 64'(exp_cmd.size()), 64'd0);
        chk({tag, "_addrs_left"}, 64'(exp_out.size()), 64'd0);
    endtask

    task automatic illegal(input int a, input int b, input int c, input string tag);
        int e0;
        int h0;
        e0 = err_cnt;
        h0 = hs_cnt;
        do_start(a, b, c);
        chk({tag, "_check_busy"}, 64'({busy, err, bfly_valid}), 64'b100);
        cyc();
        chk({tag, "_err_pulse"}, 64'({busy, err, bfly_valid}), 64'b010);
        cyc();
        chk({tag, "_after"}, 64'({busy, err, bfly_valid}), 64'b000);
        cyc();
        chk({tag, "_err_count"}, 64'(err_cnt - e0), 64'd1);
        chk({tag, "_no_cmds"}, 64'(hs_cnt - h0), 64'd0);
    endtask

    initial begin
        int h0;
        int k;

        // Reset with start held high: reset must win.
        reset = 1'b1;
        start = 1'b1;
        cfg_a = 4'd2;
        cfg_b = 2'd1;
        cyc();
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        start = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("reset_idle_busy", 64'(busy), 64'd0);

        // N=12 with ready high, latency check and a start pulse mid-run.
        rdy_fixed = 1'b1;
        push_model(2, 1, 0);
        do_start(2, 1, 0);
        chk("lat_check_cycle", 64'({busy, bfly_valid}), 64'b10);
        cyc();
        chk("lat_setup_cycle", 64'({busy, bfly_valid}), 64'b10);
        cyc();
        chk("lat_first_cmd", 64'(bfly_valid), 64'd1);
        repeat (3) cyc();
        do_start(4, 1, 2);
        wait_finish(200, "n12");

        illegal(6, 1, 2, "n4800");
        illegal(0, 0, 0, "n1");

        // Largest legal size.
        h0 = hs_cnt;
        push_model(4, 1, 2);
        do_start(4, 1, 2);
        cyc();
        cyc();
        chk("n1200_first_stride", 64'({bfly_radix, bfly_stride}), 64'({3'd5, 11'd240}));
        wait_finish(8000, "n1200");
        chk("n1200_cmd_total", 64'(hs_cnt - h0), 64'd3280);

        // Random backpressure on both handshakes.
        rnd_mode = 1'b1;
        push_model(2, 1, 0);
        do_start(2, 1, 0);
        wait_finish(2000, "n12_rand");
        rnd_mode = 1'b0;
        cyc();

        // Engine stays busy for 5 cycles after stage 1.
        eng_busy = 1'b1;
        h0 = hs_cnt;
        push_model(2, 1, 0);
        do_start(2, 1, 0);
        k = 0;
        while (hs_cnt - h0 < 4 && k < 50) begin
            cyc();
            k++;
        end
        chk("drain_stage1_done", 64'(hs_cnt - h0), 64'd4);
        for (int i = 0; i < 5; i++) begin
            chk("drain_hold_no_cmd", 64'(bfly_valid), 64'd0);
            cyc();
        end
        eng_busy = 1'b0;
        k = 0;
        while (!bfly_valid && k < 4) begin
            cyc();
            k++;
        end
        chk("drain_resume", 64'({bfly_valid, bfly_radix, bfly_stride}), 64'({1'b1, 3'd2, 11'd2}));
        wait_finish(200, "n12_drain");

        // Reset during stage 2.
        h0 = hs_cnt;
        push_model(2, 1, 0);
        do_start(2, 1, 0);
        k = 0;
        while (hs_cnt - h0 < 6 && k < 50) begin
            cyc();
            k++;
        end
        reset = 1'b1;
        cyc();
        chk("midrun_reset_outputs", 64'(all_outs()), 64'd0);
        reset = 1'b0;
        exp_cmd.delete();
        exp_out.delete();
        cyc();
        chk("midrun_reset_idle", 64'({busy, bfly_valid}), 64'd0);

        push_model(2, 1, 0);
        do_start(2, 1, 0);
        wait_finish(200, "n12_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control FSM for the mixed-radix (2/3/5) in-place FFT engine of the PUSCH transform-precoding path.
- On `start`, latches the size exponents, validates N = 2^a·3^b·5^c ≤ MAX_N, and issues one butterfly command per butterfly, stage by stage, in radix order 5, then 3, then 2.
- Waits for the engine to drain after each stage.
- Then sequences N output-read addresses to the output buffer and pulses `finish`.

Parameters:
- AW, 11, width of all address/index/count outputs.
- MAX_N, 1200, largest legal transform size.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- cfg_a  in  4  exponent of 2 (0..10)
- cfg_b  in  2  exponent of 3 (0..3)
- cfg_c  in  2  exponent of 5 (0..3)
- bfly_valid  out  1  butterfly command valid
- bfly_ready  in  1  engine accepts command
- bfly_radix  out  3  2, 3 or 5
- bfly_base  out  AW  address of point 0; point m at base + m·stride
- bfly_stride  out  AW  point spacing for the current stage
- bfly_tw  out  AW  twiddle step (= j·G); engine uses m·tw for point m
- eng_busy  in  1  engine pipeline still holds data
- out_valid  out  1  output address valid
- out_ready  in  1  output buffer accepts address
- out_addr  out  AW  natural-order read index 0..N-1
- busy  out  1  high from accept until finish cycle inclusive
- finish  out  1  one-cycle pulse after last output handshake
- err  out  1  one-cycle pulse: illegal size

Behaviour:
- Reset: state = IDLE. All outputs 0, including `bfly_radix`, `bfly_stride` and `busy`.
- Stage math:
  - Stage list = c radix-5 stages, then b radix-3 stages, then a radix-2 stages.
  - P = product of radices of all completed stages; P = 1 at start.
  - For current radix r: stride S = N/(P·r); groups G = P.
  - Butterflies issue in order g = 0..G-1 (outer), j = 0..S-1 (inner).
  - bfly_base = g·S·r + j; bfly_tw = j·G.
  - Base, j and tw are generated by counters/accumulators. The only dividers are the stride update S_next = S/r_next, for r ∈ {2, 3, 5}.
- FSM states:
  - IDLE: `start` latches cfg_*, sets busy = 1 next cycle and moves to CHECK. `start` is ignored outside IDLE.
  - CHECK (1 cycle): compute N.
    - N > MAX_N or N = 1 → err = 1 for one cycle, busy = 0, return to IDLE.
    - Otherwise → SETUP.
  - SETUP (1 cycle): load r, S, and clear g/j/tw counters.
  - ISSUE: hold `bfly_valid` with stable fields until `bfly_ready`. Advance counters on valid && ready. Back-to-back commands are allowed, so valid stays high on consecutive cycles.
    - On the handshake of the last butterfly → DRAIN, valid = 0.
  - DRAIN: wait for the first cycle with eng_busy = 0; `eng_busy` is not sampled in the handshake cycle itself.
    - If more stages remain → SETUP.
    - Otherwise → OUTPUT.
  - OUTPUT: `out_addr` runs 0..N-1, advancing on out_valid && out_ready.
    - After the last handshake → DONE.
  - DONE (1 cycle): finish = 1, then busy = 0 and return to IDLE.
- Latency: with `start` at cycle t, CHECK is at t+1, SETUP at t+2, and the first bfly_valid = 1 at t+3.
- Every stage issues exactly N/r commands.
- Reset mid-operation: abort immediately and drive all outputs to reset values. The engine must be reset alongside the sequencer.
- Simultaneous events: `start` and `reset` in the same cycle → reset wins.

Test Plan:
- Size N=12 (a=2, b=1, c=0), ready tied high:
  - Stage 1, r=3, S=4: bases 0,1,2,3; tw 0,1,2,3.
  - Stage 2, r=2, S=2: bases 0,1,4,5,8,9; tw 0,3,0,3,0,3.
  - Stage 3, r=2, S=1: bases 0,2,4,6,8,10; tw all 0.
  - Then out_addr 0..11 and a single finish pulse.
- Size N=1200 (a=4, b=1, c=2):
  - Stages in order radix 5, 5, 3, 2, 2, 2, 2, with first-stage stride 240.
  - Per-stage command counts 240, 240, 400, 600, 600, 600, 600.
  - 1200 output addresses.
- Illegal sizes:
  - a=6, b=1, c=2 (N=4800) → err pulse at cycle t+2, no bfly_valid, busy low afterwards.
  - a=b=c=0 (N=1) → err.
- Backpressure: random bfly_ready / out_ready on N=12 → fields stable while stalled, no duplicated or skipped command or address. Hold eng_busy high for 5 cycles after stage 1 → stage 2 first command waits until eng_busy falls.
- `start` pulsed mid-run (ignored, sequence unchanged). Reset asserted during stage 2 → next cycle all outputs 0. A fresh N=12 run afterwards completes correctly.
